// File: rtl/i2s_pkg.sv
// i2s_pkg: types and defaults shared by the I2S receiver and serializer.
// Holds the framing state enum and the default word/bit-count limits.
package i2s_pkg;

    localparam int I2S_DATA_W   = 24;
    localparam int I2S_MAX_BITS = 63;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: brings bck/lrck/data into clk domain, flags bck rises.
// Ports: clk, rst, bck/lrck/data in; bck_rise, lrck_s, data_s out.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bck,
    input  logic lrck,
    input  logic data,
    output logic bck_rise,
    output logic lrck_s,
    output logic data_s
);

    logic [SYNC_STAGES-1:0] bck_sr;
    logic [SYNC_STAGES-1:0] lrck_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   bck_prev;

    // Outputs are registered together so the edge flag and the
    // captured lrck/data always describe the same bck rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bck_sr   <= '0;
            lrck_sr  <= '0;
            data_sr  <= '0;
            bck_prev <= 1'b0;
            bck_rise <= 1'b0;
            lrck_s   <= 1'b0;
            data_s   <= 1'b0;
        end else begin
            bck_sr   <= {bck_sr[SYNC_STAGES-2:0], bck};
            lrck_sr  <= {lrck_sr[SYNC_STAGES-2:0], lrck};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], data};
            bck_prev <= bck_sr[SYNC_STAGES-1];
            bck_rise <= bck_sr[SYNC_STAGES-1] & ~bck_prev;
            lrck_s   <= lrck_sr[SYNC_STAGES-1];
            data_s   <= data_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S capture, emits left/right pairs with a 1-clk strobe.
// Ports: clk, rst, adc_bck/lrck/data in; sample_valid, left/right_data, locked.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BITS    = I2S_MAX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_bck,
    input  logic              adc_lrck,
    input  logic              adc_data,
    output logic              sample_valid,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              locked
);

    localparam int CNT_W = $clog2(MAX_BITS + 1);

    logic              bck_rise;
    logic              lrck_s;
    logic              data_s;
    i2s_state_e        state_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_ins;
    logic [DATA_W-1:0] left_hold;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              lrck_q;
    logic              left_ok;
    logic              boundary;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .bck     (adc_bck),
        .lrck    (adc_lrck),
        .data    (adc_data),
        .bck_rise(bck_rise),
        .lrck_s  (lrck_s),
        .data_s  (data_s)
    );

    // Current word with this bit placed MSB-first; slots past DATA_W
    // match no position and are dropped.
    always_comb begin
        word_ins = word_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(DATA_W - 1 - i)) begin
                word_ins[i] = data_s;
            end
        end
    end

    assign cnt_inc  = (cnt_q == CNT_W'(MAX_BITS)) ? cnt_q : cnt_q + 1'b1;
    assign boundary = lrck_s != lrck_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SYNC;
            word_q       <= '0;
            left_hold    <= '0;
            cnt_q        <= '0;
            lrck_q       <= 1'b0;
            left_ok      <= 1'b0;
            sample_valid <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (bck_rise) begin
                if (boundary) begin
                    // The boundary bit is the LSB slot of the ending word.
                    word_q <= '0;
                    cnt_q  <= '0;
                    lrck_q <= lrck_s;
                    unique case (state_q)
                        SYNC: begin
                            state_q <= lrck_s ? RIGHT : LEFT;
                        end
                        LEFT: begin
                            if (lrck_s) begin
                                left_hold <= word_ins;
                                left_ok   <= 1'b1;
                                state_q   <= RIGHT;
                            end
                        end
                        RIGHT: begin
                            if (!lrck_s) begin
                                if (left_ok) begin
                                    left_data    <= left_hold;
                                    right_data   <= word_ins;
                                    sample_valid <= 1'b1;
                                    locked       <= 1'b1;
                                end
                                left_ok <= 1'b0;
                                state_q <= LEFT;
                            end
                        end
                        default: state_q <= SYNC;
                    endcase
                end else begin
                    word_q <= word_ins;
                    cnt_q  <= cnt_inc;
                    // Word ran too long: lrck is lost, restart framing.
                    if (cnt_inc == CNT_W'(MAX_BITS)) begin
                        locked  <= 1'b0;
                        left_ok <= 1'b0;
                        state_q <= SYNC;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx driving Philips I2S frames.
// Expected pairs are queued at send time and popped on each strobe.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_bck = 1'b0;
    logic        adc_lrck = 1'b0;
    logic        adc_data = 1'b0;
    logic        sample_valid;
    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        locked;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] sb[$];
    longint      cyc = 0;
    longint      last_cyc = -1;
    logic [63:0] lb_time = 64'd0;
    bit          chk_period = 1'b0;
    bit          prev_sv = 1'b0;
    bit          pend = 1'b0;
    bit          prev_l = 1'b0;

    i2s_rx dut (
        .clk         (clk),
        .rst         (rst),
        .adc_bck     (adc_bck),
        .adc_lrck    (adc_lrck),
        .adc_data    (adc_data),
        .sample_valid(sample_valid),
        .left_data   (left_data),
        .right_data  (right_data),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] align(input logic [31:0] w, input int n);
        logic [31:0] t;
        if (n >= 24) t = w >> (n - 24);
        else         t = w << (24 - n);
        return t[23:0];
    endfunction

    // One bck slot: data/lrck change while bck low, sampled on the rise.
    task automatic drive_bit(input bit l, input bit d);
        adc_lrck = l;
        adc_data = d;
        #20;
        adc_bck = 1'b1;
        if (prev_l && !l) lb_time = $time;
        prev_l = l;
        #20;
        adc_bck = 1'b0;
    endtask

    task automatic send_chan(input bit ch, input logic [31:0] w, input int n,
                             input int from, input int to);
        logic [31:0] t;
        for (int i = from; i < to; i++) begin
            if (i == 0) begin
                drive_bit(ch, pend);
            end else begin
                t = w >> (n - i);
                drive_bit(ch, t[0]);
            end
        end
        if (to == n) pend = w[0];
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              input int n, input bit exp);
        if (exp) sb.push_back({align(lw, n), align(rw, n)});
        send_chan(1'b0, lw, n, 0, n);
        send_chan(1'b1, rw, n, 0, n);
    endtask

    task automatic flush();
        send_chan(1'b0, 32'd0, 32, 0, 2);
        #400;
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1, 1'($urandom_range(1)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #8;
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_left", 64'(left_data), 64'd0);
        check("rst_right", 64'(right_data), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        #2;
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        if (prev_sv) check("strobe_width", 64'(sample_valid), 64'd0);
        if (sample_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("left", 64'(left_data), 64'(e[47:24]));
                check("right", 64'(right_data), 64'(e[23:0]));
            end
            check("locked", 64'(locked), 64'd1);
            check("latency", $time - lb_time, 64'd38);
            if (chk_period && last_cyc >= 0)
                check("period", 64'(cyc - last_cyc), 64'd256);
            last_cyc = cyc;
        end
        prev_sv = sample_valid;
    end

    initial begin
        #2;
        do_reset();

        // 24-bit samples in 32-bit slots, repeated
        chk_period = 1'b1;
        preamble(2);
        for (int k = 0; k < 4; k++)
            send_frame(32'h1234_5600, 32'hABCD_EF00, 32, 1'b1);

        // 16-bit words, zero padded at the LSB end
        chk_period = 1'b0;
        for (int k = 0; k < 2; k++)
            send_frame(32'h0000_8001, 32'h0000_7FFF, 16, 1'b1);

        // 32-bit words, truncated to 24
        for (int k = 0; k < 2; k++)
            send_frame(32'hA5A5_A5FF, 32'h0000_0001, 32, 1'b1);
        flush();

        // stream starts mid right word
        do_reset();
        preamble(10);
        send_frame(32'h0F0F_0F00, 32'hF0F0_F000, 32, 1'b1);
        send_frame(32'h7654_3200, 32'h89AB_CD00, 32, 1'b1);

        // reset in the middle of a left word
        send_chan(1'b0, 32'h1111_1100, 32, 0, 10);
        do_reset();
        send_chan(1'b0, 32'h1111_1100, 32, 10, 32);
        send_chan(1'b1, 32'h2222_2200, 32, 0, 32);
        send_frame(32'h3333_3300, 32'hCCCC_CC00, 32, 1'b1);
        flush();

        // lrck stuck low long enough to lose framing
        do_reset();
        preamble(2);
        send_frame(32'h1234_5600, 32'hABCD_EF00, 32, 1'b1);
        send_frame(32'h5555_5500, 32'hAAAA_AA00, 32, 1'b1);
        drive_bit(1'b0, pend);
        for (int i = 1; i < 10; i++) drive_bit(1'b0, 1'b0);
        check("lock_before_stuck", 64'(locked), 64'd1);
        for (int i = 10; i < 70; i++) drive_bit(1'b0, 1'b0);
        check("lock_lost", 64'(locked), 64'd0);
        send_frame(32'hDEAD_BE00, 32'hFEED_0000, 32, 1'b0);
        send_frame(32'h0123_4500, 32'hFEDC_BA00, 32, 1'b1);
        flush();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (ADC interface) that accepts an externally driven bit clock, word clock and serial data.
- Synchronizes the three inputs into the system clock domain and deserializes Philips-format I2S, MSB first, one-bit delay after an LRCK edge.
- Presents left/right 2's-complement samples as a pair with a one-cycle strobe.
- Companion to the DAC-side serializer; the capture side of the audio path.

Parameters:
DATA_W, 24, sample width per channel on left_data/right_data
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2)
MAX_BITS, 63, saturating per-word bit count; reaching it means a lost LRCK

Ports:
clk  input  1  system clock; frequency must be at least 4x adc_bck
rst  input  1  synchronous active-high reset
adc_bck  input  1  I2S bit clock from ADC (asynchronous to clk)
adc_lrck  input  1  I2S word clock; 0 = left, 1 = right
adc_data  input  1  I2S serial data, valid on adc_bck rising edge
sample_valid  output  1  one-clk strobe: left_data/right_data hold a new pair
left_data  output  DATA_W  left sample, 2's complement
right_data  output  DATA_W  right sample, 2's complement
locked  output  1  high while framing is tracked

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - sample_valid=0, left_data=0, right_data=0, locked=0.
  - Shift register, bit count and left hold are cleared; state goes to SYNC.
  - Any partial word is discarded. This applies equally to a mid-frame reset.
- Input path:
  - Each input passes through SYNC_STAGES flops.
  - bck_rise = synchronized bck high AND previous synchronized bck low.
  - All capture logic acts only in clk cycles where bck_rise=1.
- On each bck_rise: capture bit d = sync data and l = sync lrck, then compare l with lrck_q, the lrck registered at the previous bck_rise.
- Non-boundary (l == lrck_q):
  - If cnt < DATA_W, write d to word[DATA_W-1-cnt].
  - Bits beyond DATA_W are ignored (truncation).
  - cnt increments, saturating at MAX_BITS.
- Boundary (l != lrck_q):
  - d is the LSB slot of the ending word; write it if cnt < DATA_W.
  - The ending word is complete. Words shorter than DATA_W are zero-padded at the LSB end because word is cleared at word start.
  - Then clear word, set cnt=0, set lrck_q=l.
- States: SYNC, LEFT, RIGHT.
  - SYNC: ignore data and wait for the first boundary. Go to LEFT if l=0, RIGHT if l=1. The word ending at this boundary is discarded.
  - LEFT, boundary with l=1: latch word into left_hold, set left_ok=1, go to RIGHT.
  - RIGHT, boundary with l=0: if left_ok, then left_data<=left_hold, right_data<=word, sample_valid=1 for exactly one clk, locked=1. Clear left_ok and go to LEFT.
  - RIGHT, boundary without left_ok (first word was right): no strobe.
- Latency: sample_valid asserts exactly SYNC_STAGES+1 clk edges after the clk edge that first samples the adc_bck rise ending the right word. This latency is fixed.
- Loss of framing: if cnt reaches MAX_BITS (LRCK stuck), then:
  - locked<=0, left_ok<=0, state<=SYNC;
  - left_data/right_data keep their last values;
  - no strobe until a new full left+right pair arrives.
- Outputs are stable between strobes. A downstream consumer may sample them any time after sample_valid.
- Simultaneous rst and bck_rise: reset wins.

Decomposition:
- Shared package (i2s_pkg): state enum {SYNC, LEFT, RIGHT}, default DATA_W=24, MAX_BITS=63. The package is shared with the DAC-side serializer.
- One sub-module, i2s_sync_edge: SYNC_STAGES synchronizer for bck/lrck/data plus the bck rising-edge detector. Its outputs are bck_rise, data_s and lrck_s, aligned to the same cycle.

Test Plan:
- 24-bit words, 32 bck per channel, clk = 4x bck, left=0x123456, right=0xABCDEF, repeated.
  - After reset, the first strobe carries left_data=0x123456 and right_data=0xABCDEF.
  - locked=1 from that strobe.
  - Strobe width is 1 clk; strobes repeat every 256 clk.
- 16-bit words, 16 bck per channel, left=0x8001, right=0x7FFF -> left_data=0x800100, right_data=0x7FFF00.
- 32-bit words, left=0xA5A5A5FF, right=0x00000001 -> left_data=0xA5A5A5, right_data=0x000000 (truncation).
- Stream starts mid-right-word after reset -> that word and the unpaired state are discarded; the first strobe comes only after a complete left then right word.
- rst pulsed mid-left-word while streaming:
  - outputs read 0 and locked=0 the next cycle;
  - no strobe for the interrupted frame;
  - correct pair on the first complete subsequent frame.
- adc_lrck held constant for 70 bck after lock:
  - locked falls when cnt hits 63;
  - no strobes;
  - on resumed framing, locked returns at the first full pair.
